// File: rtl/wt_dcache_rrip_repl.sv
// RRIP replacement state for the write-through L1 dcache: victim selection with
// single-step set aging, SRRIP/BRRIP/predictor insertion and a set-by-set flush.
module wt_dcache_rrip_repl #(
    parameter int NUM_SETS   = 256,
    parameter int NUM_WAYS   = 4,
    parameter int RRPV_W     = 2,
    parameter int BIP_PERIOD = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [1:0]                  mode_i,
    input  logic                        hit_i,
    input  logic [$clog2(NUM_SETS)-1:0] hit_idx_i,
    input  logic [$clog2(NUM_WAYS)-1:0] hit_way_i,
    input  logic                        miss_req_i,
    input  logic [$clog2(NUM_SETS)-1:0] miss_idx_i,
    input  logic [RRPV_W-1:0]           pred_i,
    output logic                        miss_ready_o,
    output logic                        victim_valid_o,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way_o,
    output logic                        conflict_o,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int BIP_W = $clog2(BIP_PERIOD);

    localparam logic [RRPV_W-1:0] RRPV_MAX  = {RRPV_W{1'b1}};
    localparam logic [RRPV_W-1:0] RRPV_LONG = RRPV_MAX - RRPV_W'(1'b1);
    localparam logic [RRPV_W-1:0] RRPV_ZERO = {RRPV_W{1'b0}};
    localparam logic [IDX_W-1:0]  LAST_SET  = IDX_W'(NUM_SETS - 1);
    localparam logic [BIP_W-1:0]  BIP_LAST  = BIP_W'(BIP_PERIOD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e                             state_r;
    logic [IDX_W-1:0]                   cnt_r;
    logic [BIP_W-1:0]                   bip_r;
    logic [NUM_WAYS-1:0][RRPV_W-1:0]    rrpv_r [NUM_SETS];
    logic                               victim_valid_r;
    logic [WAY_W-1:0]                   victim_way_r;
    logic                               conflict_r;

    logic                               miss_acc_s;
    logic                               hit_en_s;
    logic                               same_set_s;
    logic                               conflict_s;
    logic [NUM_WAYS-1:0][RRPV_W-1:0]    miss_set_s;
    logic [NUM_WAYS-1:0][RRPV_W-1:0]    aged_s;
    logic [NUM_WAYS-1:0][RRPV_W-1:0]    miss_new_s;
    logic [RRPV_W-1:0]                  max_s;
    logic [RRPV_W-1:0]                  delta_s;
    logic [RRPV_W-1:0]                  ins_s;
    logic [WAY_W-1:0]                   victim_s;

    assign miss_ready_o   = (state_r == ST_IDLE);
    assign busy_o         = (state_r == ST_FLUSH);
    assign victim_valid_o = victim_valid_r;
    assign victim_way_o   = victim_way_r;
    assign conflict_o     = conflict_r;

    // Accept/qualify requests; hits are ignored while flushing.
    always_comb begin
        miss_acc_s = miss_req_i && (state_r == ST_IDLE);
        hit_en_s   = hit_i && (state_r == ST_IDLE);
        same_set_s = (hit_idx_i == miss_idx_i);
        conflict_s = miss_acc_s && hit_en_s && same_set_s;
    end

    // Age the miss set in one step, pick the victim and build the updated set.
    always_comb begin
        miss_set_s = rrpv_r[miss_idx_i];
        max_s      = RRPV_ZERO;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (miss_set_s[w] > max_s) begin
                max_s = miss_set_s[w];
            end else begin
                max_s = max_s;
            end
        end
        delta_s = RRPV_MAX - max_s;
        for (int w = 0; w < NUM_WAYS; w++) begin
            aged_s[w] = miss_set_s[w] + delta_s;
        end
        // Scan downwards so the lowest matching way is the one left standing.
        victim_s = {WAY_W{1'b0}};
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (aged_s[w] == RRPV_MAX) begin
                victim_s = WAY_W'(w);
            end else begin
                victim_s = victim_s;
            end
        end
        case (mode_i)
            2'd1:    ins_s = (bip_r == {BIP_W{1'b0}}) ? RRPV_LONG : RRPV_MAX;
            2'd2:    ins_s = pred_i;
            default: ins_s = RRPV_LONG;
        endcase
        miss_new_s           = aged_s;
        miss_new_s[victim_s] = ins_s;
        // A same-set hit on another way is promoted after the miss update;
        // a hit on the victim itself is dropped.
        if (conflict_s && (hit_way_i != victim_s)) begin
            miss_new_s[hit_way_i] = RRPV_ZERO;
        end else begin
            miss_new_s = miss_new_s;
        end
    end

    // RRPV array: flush write, miss update (with merged same-set hit) or hit promotion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rrpv_r[s] <= {NUM_WAYS{RRPV_MAX}};
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (state_r == ST_FLUSH) begin
                    if (cnt_r == IDX_W'(s)) begin
                        rrpv_r[s] <= {NUM_WAYS{RRPV_MAX}};
                    end
                end else if (miss_acc_s && (miss_idx_i == IDX_W'(s))) begin
                    rrpv_r[s] <= miss_new_s;
                end else if (hit_en_s && (hit_idx_i == IDX_W'(s))) begin
                    rrpv_r[s][hit_way_i] <= RRPV_ZERO;
                end
            end
        end
    end

    // Flush FSM with its set counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_i) begin
                        state_r <= ST_FLUSH;
                        cnt_r   <= {IDX_W{1'b0}};
                    end
                end
                ST_FLUSH: begin
                    if (flush_i) begin
                        cnt_r <= {IDX_W{1'b0}};
                    end else if (cnt_r == LAST_SET) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {IDX_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + IDX_W'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // BRRIP long-insert counter, advanced by each accepted BRRIP miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bip_r <= {BIP_W{1'b0}};
        end else if (miss_acc_s && (mode_i == 2'd1)) begin
            if (bip_r == BIP_LAST) begin
                bip_r <= {BIP_W{1'b0}};
            end else begin
                bip_r <= bip_r + BIP_W'(1'b1);
            end
        end
    end

    // Registered victim result; the way holds between misses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            victim_valid_r <= 1'b0;
            victim_way_r   <= {WAY_W{1'b0}};
            conflict_r     <= 1'b0;
        end else begin
            victim_valid_r <= miss_acc_s;
            conflict_r     <= conflict_s;
            if (miss_acc_s) begin
                victim_way_r <= victim_s;
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_rrip_repl.sv
// Bench for wt_dcache_rrip_repl: directed vector table, flush/reset sequences and
// randomized traffic against an "age until something is distant" reference model.
module tb_wt_dcache_rrip_repl;

    localparam int NS = 16;
    localparam int NW = 4;

    logic       clk_i      = 1'b0;
    logic       rst_ni     = 1'b1;
    logic       flush_i    = 1'b0;
    logic [1:0] mode_i     = 2'd0;
    logic       hit_i      = 1'b0;
    logic [3:0] hit_idx_i  = 4'd0;
    logic [1:0] hit_way_i  = 2'd0;
    logic       miss_req_i = 1'b0;
    logic [3:0] miss_idx_i = 4'd0;
    logic [1:0] pred_i     = 2'd0;
    logic       miss_ready_o;
    logic       victim_valid_o;
    logic [1:0] victim_way_o;
    logic       conflict_o;
    logic       busy_o;

    wt_dcache_rrip_repl #(
        .NUM_SETS(NS), .NUM_WAYS(NW), .RRPV_W(2), .BIP_PERIOD(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .mode_i(mode_i),
        .hit_i(hit_i), .hit_idx_i(hit_idx_i), .hit_way_i(hit_way_i),
        .miss_req_i(miss_req_i), .miss_idx_i(miss_idx_i), .pred_i(pred_i),
        .miss_ready_o(miss_ready_o), .victim_valid_o(victim_valid_o),
        .victim_way_o(victim_way_o), .conflict_o(conflict_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_rrpv [NS][NW];
    bit m_busy;
    int m_cnt;
    int m_bip;
    int m_way;

    typedef struct {
        bit m; int mi; int md; int pr;
        bit h; int hi; int hw;
        bit ev; int ew; bit ec;
        bit cs; int cset; int cval;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_pack(input int s);
        logic [7:0] v;
        for (int w = 0; w < NW; w++) v[2*w +: 2] = 2'(m_rrpv[s][w]);
        return v;
    endfunction

    function automatic int dut_set(input int s);
        logic [7:0] v;
        v = dut.rrpv_r[s];
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) m_rrpv[s][w] = 3;
        m_busy = 1'b0; m_cnt = 0; m_bip = 0; m_way = 0;
    endtask

    task automatic model_step(input bit fl, input int md, input bit h, input int hi,
                              input int hw, input bit m, input int mi, input int pr,
                              output bit ev, output bit ec);
        bit found;
        int v;
        int ins;
        ev = 1'b0; ec = 1'b0;
        if (m_busy) begin
            for (int w = 0; w < NW; w++) m_rrpv[m_cnt][w] = 3;
            if (fl) m_cnt = 0;
            else if (m_cnt == NS - 1) begin m_busy = 1'b0; m_cnt = 0; end
            else m_cnt++;
        end else begin
            if (m) begin
                found = 1'b0;
                while (!found) begin
                    for (int w = 0; w < NW; w++) if (m_rrpv[mi][w] == 3) found = 1'b1;
                    if (!found) for (int w = 0; w < NW; w++) m_rrpv[mi][w]++;
                end
                v = -1;
                for (int w = NW - 1; w >= 0; w--) if (m_rrpv[mi][w] == 3) v = w;
                case (md)
                    1: begin ins = (m_bip == 0) ? 2 : 3; m_bip = (m_bip + 1) % 4; end
                    2: ins = pr;
                    default: ins = 2;
                endcase
                m_rrpv[mi][v] = ins;
                m_way = v;
                ev = 1'b1;
                ec = h && (hi == mi);
                if (h && (hi == mi) && (hw != v)) m_rrpv[mi][hw] = 0;
            end
            if (h && !(m && hi == mi)) m_rrpv[hi][hw] = 0;
            if (fl) begin m_busy = 1'b1; m_cnt = 0; end
        end
    endtask

    task automatic cycle(input bit fl, input int md, input bit h, input int hi, input int hw,
                         input bit m, input int mi, input int pr);
        bit ev, ec;
        flush_i = fl; mode_i = 2'(md); hit_i = h; hit_idx_i = 4'(hi); hit_way_i = 2'(hw);
        miss_req_i = m; miss_idx_i = 4'(mi); pred_i = 2'(pr);
        #1;
        chk("ready_pre", int'(miss_ready_o), int'(!m_busy));
        model_step(fl, md, h, hi, hw, m, mi, pr, ev, ec);
        @(posedge clk_i); #1;
        chk("victim_valid", int'(victim_valid_o), int'(ev));
        chk("victim_way", int'(victim_way_o), m_way);
        chk("conflict", int'(conflict_o), int'(ec));
        chk("busy", int'(busy_o), int'(m_busy));
        chk("ready", int'(miss_ready_o), int'(!m_busy));
        chk("state_miss_set", dut_set(mi), int'(m_pack(mi)));
        chk("state_hit_set", dut_set(hi), int'(m_pack(hi)));
        flush_i = 1'b0; hit_i = 1'b0; miss_req_i = 1'b0;
    endtask

    function automatic vec_t mk(input bit m, input int mi, input int md, input int pr,
                                input bit h, input int hi, input int hw,
                                input bit ev, input int ew, input bit ec,
                                input bit cs, input int cset, input int cval);
        vec_t r;
        r.m = m; r.mi = mi; r.md = md; r.pr = pr; r.h = h; r.hi = hi; r.hw = hw;
        r.ev = ev; r.ew = ew; r.ec = ec; r.cs = cs; r.cset = cset; r.cval = cval;
        return r;
    endfunction

    task automatic reset_dut();
        @(negedge clk_i);
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int n_busy;
        model_reset();
        // Directed vectors; expected values derived by hand from the replacement rules.
        tbl[0]  = mk(1'b1, 5, 0, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 5, 8'hFE);
        tbl[1]  = mk(1'b1, 5, 0, 0, 1'b0, 0, 0, 1'b1, 1, 1'b0, 1'b1, 5, 8'hFA);
        tbl[2]  = mk(1'b1, 5, 0, 0, 1'b0, 0, 0, 1'b1, 2, 1'b0, 1'b1, 5, 8'hEA);
        tbl[3]  = mk(1'b1, 5, 0, 0, 1'b0, 0, 0, 1'b1, 3, 1'b0, 1'b1, 5, 8'hAA);
        tbl[4]  = mk(1'b0, 0, 0, 0, 1'b1, 7, 0, 1'b0, 3, 1'b0, 1'b0, 0, 8'h00);
        tbl[5]  = mk(1'b0, 0, 0, 0, 1'b1, 7, 1, 1'b0, 3, 1'b0, 1'b0, 0, 8'h00);
        tbl[6]  = mk(1'b0, 0, 0, 0, 1'b1, 7, 2, 1'b0, 3, 1'b0, 1'b0, 0, 8'h00);
        tbl[7]  = mk(1'b0, 0, 0, 0, 1'b1, 7, 3, 1'b0, 3, 1'b0, 1'b1, 7, 8'h00);
        tbl[8]  = mk(1'b1, 7, 0, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 7, 8'hFE);
        tbl[9]  = mk(1'b1, 9, 2, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 9, 8'hFC);
        tbl[10] = mk(1'b1, 10, 1, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 10, 8'hFE);
        tbl[11] = mk(1'b1, 11, 1, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 11, 8'hFF);
        tbl[12] = mk(1'b1, 12, 1, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 12, 8'hFF);
        tbl[13] = mk(1'b1, 13, 1, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 13, 8'hFF);
        tbl[14] = mk(1'b1, 14, 1, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 14, 8'hFE);
        tbl[15] = mk(1'b1, 3, 0, 0, 1'b1, 3, 2, 1'b1, 0, 1'b1, 1'b1, 3, 8'hCE);
        tbl[16] = mk(1'b1, 4, 0, 0, 1'b1, 4, 0, 1'b1, 0, 1'b1, 1'b1, 4, 8'hFE);
        tbl[17] = mk(1'b1, 6, 3, 0, 1'b1, 5, 1, 1'b1, 0, 1'b0, 1'b1, 5, 8'hA2);
        tbl[18] = mk(1'b1, 5, 0, 0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 5, 8'hF6);
        tbl[19] = mk(1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 6, 8'hFE);
        tbl[20] = mk(1'b1, 8, 2, 1, 1'b1, 3, 3, 1'b1, 0, 1'b0, 1'b1, 8, 8'hFD);

        // Power-on reset
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_ready", int'(miss_ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(victim_valid_o), 0);
        chk("rst_conflict", int'(conflict_o), 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        chk("rst_set5", dut_set(5), 8'hFF);

        // Table-driven directed vectors
        for (int i = 0; i < 21; i++) begin
            cycle(1'b0, tbl[i].md, tbl[i].h, tbl[i].hi, tbl[i].hw, tbl[i].m, tbl[i].mi, tbl[i].pr);
            chk($sformatf("tbl%0d_valid", i), int'(victim_valid_o), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_way", i), int'(victim_way_o), tbl[i].ew);
            chk($sformatf("tbl%0d_conflict", i), int'(conflict_o), int'(tbl[i].ec));
            if (tbl[i].cs) chk($sformatf("tbl%0d_set", i), dut_set(tbl[i].cset), tbl[i].cval);
        end

        // Flush: busy for exactly NS cycles, misses and hits ignored meanwhile
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        n_busy = 0;
        for (int i = 0; i < 40 && busy_o; i++) begin
            n_busy++;
            chk("flush_not_ready", int'(miss_ready_o), 0);
            cycle(1'b0, 0, 1'b1, i % NS, i % NW, 1'b1, (i + 3) % NS, 0);
            chk("flush_no_victim", int'(victim_valid_o), 0);
        end
        chk("flush_len", n_busy, NS);
        for (int s = 0; s < NS; s++) chk($sformatf("flush_set%0d", s), dut_set(s), 8'hFF);
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1, 5, 0);
        chk("post_flush_victim", int'(victim_way_o), 0);
        chk("post_flush_valid", int'(victim_valid_o), 1);

        // Flush together with an accepted miss: miss completes, then flush runs
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b1, 9, 0);
        chk("miss_flush_valid", int'(victim_valid_o), 1);
        chk("miss_flush_busy", int'(busy_o), 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        n_busy = 0;
        for (int i = 0; i < 40 && busy_o; i++) begin
            n_busy++;
            cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        end
        chk("flush_restart_len", n_busy, NS);

        // Asynchronous reset in the fifth flush cycle
        cycle(1'b0, 0, 1'b1, 2, 1, 1'b1, 2, 0);
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        #2 rst_ni = 1'b0;
        model_reset();
        #1;
        chk("midflush_busy", int'(busy_o), 0);
        chk("midflush_ready", int'(miss_ready_o), 1);
        chk("midflush_valid", int'(victim_valid_o), 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int s = 0; s < NS; s++) chk($sformatf("rst_set%0d", s), dut_set(s), 8'hFF);

        // Asynchronous reset while a victim pulse is out
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1, 1, 0);
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1, 1, 0);
        chk("midmiss_pulse", int'(victim_valid_o), 1);
        #2 rst_ni = 1'b0;
        model_reset();
        #1;
        chk("midmiss_valid", int'(victim_valid_o), 0);
        chk("midmiss_way", int'(victim_way_o), 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);

        // Randomized traffic, concentrated on a few sets to provoke conflicts
        for (int i = 0; i < 3000; i++) begin
            bit fl, h, m;
            int md, hi, hw, mi, pr;
            fl = ($urandom_range(0, 149) == 0);
            md = $urandom_range(0, 3);
            h  = $urandom_range(0, 1);
            m  = $urandom_range(0, 1);
            hi = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NS - 1);
            mi = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NS - 1);
            hw = $urandom_range(0, NW - 1);
            pr = $urandom_range(0, 3);
            cycle(fl, md, h, hi, hw, m, mi, pr);
        end
        for (int s = 0; s < NS; s++) chk($sformatf("final_set%0d", s), dut_set(s), int'(m_pack(s)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
